// File: rtl/mxv_dot_engine.sv
// mxv_dot_engine
// Sequential unsigned dot-product engine fed by two upstream FIFOs, one for
// matrix-row elements and one for vector elements. Each element pair takes two
// cycles: a pop cycle, then a multiply-accumulate cycle on the FIFO read data.
// The finished sum is held on result/result_valid until result_ready is high.
//
// Parameters
//   DW      operand element width
//   N_ELEM  element pairs per dot product (2 or more)
//   ACC_W   accumulator / result width
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   row_data       matrix-row FIFO read data (valid the cycle after row_pop)
//   row_empty      matrix-row FIFO empty flag
//   row_pop        matrix-row FIFO pop strobe
//   vec_data       vector FIFO read data (valid the cycle after vec_pop)
//   vec_empty      vector FIFO empty flag
//   vec_pop        vector FIFO pop strobe
//   result         completed dot product
//   result_valid   result holds a completed dot product
//   result_ready   downstream accepts result
//   busy           product in progress or awaiting handoff
//
// Build option
//   MXV_DOT_SAT_EN  when defined, accumulation saturates to all-ones instead
//                   of wrapping modulo 2^ACC_W.

module mxv_dot_engine #(
  parameter int DW     = 8,
  parameter int N_ELEM = 4,
  parameter int ACC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    row_data,
  input  logic             row_empty,
  output logic             row_pop,
  input  logic [DW-1:0]    vec_data,
  input  logic             vec_empty,
  output logic             vec_pop,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int CNT_W  = $clog2(N_ELEM + 1);
  localparam int PROD_W = 2 * DW;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    MAC,
    DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [ACC_W-1:0]   result_reg;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [PROD_W-1:0]  product;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_mac;
  logic               pop_ok;
  logic               pop_now;
  logic               last_elem;

  // Both FIFOs must have data; pops are also held off while reset is high so
  // nothing is consumed before the engine is running.
  assign pop_ok    = !row_empty && !vec_empty && !rst;
  assign last_elem = (cnt_reg == CNT_W'(N_ELEM - 1));

  assign product   = PROD_W'(row_data) * PROD_W'(vec_data);

  // The first MAC of a product starts from zero rather than the stale sum.
  assign acc_base  = (cnt_reg == '0) ? '0 : acc_reg;

`ifdef MXV_DOT_SAT_EN
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [ACC_W-1:0] ACC_ALL1 = '1;

  logic [SUM_W-1:0] sum_full;

  // Once acc reaches all-ones any further non-negative addend keeps the true
  // sum above the limit, so the clamp is naturally sticky within a product.
  assign sum_full = SUM_W'(acc_base) + SUM_W'(product);
  assign acc_mac  = (sum_full > SUM_W'(ACC_ALL1)) ? ACC_ALL1 : ACC_W'(sum_full);
`else
  assign acc_mac  = acc_base + ACC_W'(product);
`endif

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    pop_now    = 1'b0;
    case (state_reg)
      IDLE, POP: begin
        if (pop_ok) begin
          pop_now    = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        acc_next   = acc_mac;
        cnt_next   = cnt_reg + CNT_W'(1);
        state_next = last_elem ? DONE : POP;
      end
      DONE: begin
        if (result_ready) begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      // Capture the final sum on the MAC -> DONE transition so result is
      // already correct in the first DONE cycle.
      if (state_reg == MAC && last_elem) begin
        result_reg <= acc_mac;
      end
    end
  end

  assign row_pop      = pop_now;
  assign vec_pop      = pop_now;
  assign result       = result_reg;
  assign result_valid = (state_reg == DONE);
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_mxv_dot_engine.sv
// Testbench for mxv_dot_engine (default parameters). Models both upstream
// FIFOs with registered read data, feeds table-driven products, and checks
// results through an expected-value queue popped at each handoff.

module tb_mxv_dot_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  row_data;
  logic        row_empty;
  logic        row_pop;
  logic [7:0]  vec_data;
  logic        vec_empty;
  logic        vec_pop;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  mxv_dot_engine #(.DW(8), .N_ELEM(4), .ACC_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .row_data     (row_data),
    .row_empty    (row_empty),
    .row_pop      (row_pop),
    .vec_data     (vec_data),
    .vec_empty    (vec_empty),
    .vec_pop      (vec_pop),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rows;   // element k in bits [8k+7:8k]
    logic [31:0] vecs;
    logic [15:0] expv;
  } entry_t;

  entry_t      tbl [6];
  logic [7:0]  row_q [$];
  logic [7:0]  vec_q [$];
  logic [15:0] exp_q [$];
  int          handoff_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int row_pops = 0;
  int vec_pops = 0;
  int valid_cycles = 0;
  int rule_viol    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO model: pop strobes sampled mid-cycle, read data registered on the edge.
  initial begin : fifo_model
    logic pr, pv;
    forever begin
      @(negedge clk);
      pr = row_pop;
      pv = vec_pop;
      if (pr != pv) rule_viol++;
      if (pr && row_empty) rule_viol++;
      if (pv && vec_empty) rule_viol++;
      @(posedge clk);
      #1;
      if (pr && row_q.size() > 0) begin
        row_data = row_q.pop_front();
        row_pops++;
      end
      if (pv && vec_q.size() > 0) begin
        vec_data = vec_q.pop_front();
        vec_pops++;
      end
      row_empty = (row_q.size() == 0);
      vec_empty = (vec_q.size() == 0);
    end
  end

  // Scoreboard side: compare at every handoff.
  initial forever begin
    @(negedge clk);
    if (result_valid) valid_cycles++;
    if (result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got %0d, expected no result", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
      handoff_q.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_rows(input logic [31:0] rows);
    for (int k = 0; k < 4; k++) row_q.push_back(rows[8*k +: 8]);
    row_empty = (row_q.size() == 0);
  endtask

  task automatic push_vecs(input logic [31:0] vecs, input int first, input int count);
    for (int k = first; k < first + count; k++) vec_q.push_back(vecs[8*k +: 8]);
    vec_empty = (vec_q.size() == 0);
  endtask

  task automatic load(input int i);
    push_rows(tbl[i].rows);
    push_vecs(tbl[i].vecs, 0, 4);
    exp_q.push_back(tbl[i].expv);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d results pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run_entry(input int i);
    int pr0, pv0, vc0;
    pr0 = row_pops;
    pv0 = vec_pops;
    vc0 = valid_cycles;
    load(i);
    drain("entry");
    check("entry_row_pops", row_pops - pr0, 4);
    check("entry_vec_pops", vec_pops - pv0, 4);
    check("entry_valid_cycles", valid_cycles - vc0, 1);
  endtask

  initial begin
    int pr0, pv0, vc0, h0;
    rst = 1'b1;
    result_ready = 1'b1;
    row_empty = 1'b1;
    vec_empty = 1'b1;
    row_data = '0;
    vec_data = '0;

    tbl[0] = '{rows: {8'd4, 8'd3, 8'd2, 8'd1},     vecs: {8'd8, 8'd7, 8'd6, 8'd5},     expv: 16'd70};
`ifdef MXV_DOT_SAT_EN
    tbl[1] = '{rows: 32'hFFFF_FFFF,                 vecs: 32'hFFFF_FFFF,                expv: 16'd65535};
    tbl[5] = '{rows: {8'd1, 8'd1, 8'd255, 8'd255},  vecs: {8'd1, 8'd1, 8'd255, 8'd255}, expv: 16'd65535};
`else
    tbl[1] = '{rows: 32'hFFFF_FFFF,                 vecs: 32'hFFFF_FFFF,                expv: 16'd63492};
    tbl[5] = '{rows: {8'd1, 8'd1, 8'd255, 8'd255},  vecs: {8'd1, 8'd1, 8'd255, 8'd255}, expv: 16'd64516};
`endif
    tbl[2] = '{rows: 32'h0,                         vecs: {8'd9, 8'd9, 8'd9, 8'd9},     expv: 16'd0};
    tbl[3] = '{rows: {8'd40, 8'd30, 8'd20, 8'd10},  vecs: {8'd1, 8'd1, 8'd1, 8'd1},     expv: 16'd100};
    tbl[4] = '{rows: {8'd7, 8'd3, 8'd100, 8'd200},  vecs: {8'd11, 8'd9, 8'd2, 8'd150},  expv: 16'd30304};

    // Reset state, with data already waiting in both FIFOs.
    repeat (2) @(posedge clk);
    #2;
    pr0 = row_pops;
    pv0 = vec_pops;
    vc0 = valid_cycles;
    load(0);
    @(negedge clk);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_row_pop", row_pop, 0);
    check("rst_vec_pop", vec_pop, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Basic product: 1*5+2*6+3*7+4*8.
    drain("basic");
    check("basic_row_pops", row_pops - pr0, 4);
    check("basic_vec_pops", vec_pops - pv0, 4);
    check("basic_valid_cycles", valid_cycles - vc0, 1);

    // Remaining table entries, including wrap/saturation cases.
    for (int i = 1; i < 6; i++) run_entry(i);

    // Back-to-back: 8 pairs preloaded.
    h0 = handoff_q.size();
    load(0);
    load(3);
    drain("b2b");
    check("b2b_count", handoff_q.size() - h0, 2);
    if (handoff_q.size() >= h0 + 2)
      check("b2b_spacing", handoff_q[h0+1] - handoff_q[h0], 9);

    // Backpressure: hold result_ready low for 5 valid cycles with more data queued.
    result_ready = 1'b0;
    load(4);
    load(2);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (result_valid) break;
    end
    check("bp_valid_rise", result_valid, 1);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      check("bp_result", result, tbl[4].expv);
      check("bp_valid", result_valid, 1);
      check("bp_no_pop", row_pop | vec_pop, 0);
    end
    @(posedge clk);
    #2;
    result_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", result_valid, 0);
    drain("bp");

    // Starvation: vector FIFO runs dry after two elements.
    pr0 = row_pops;
    pv0 = vec_pops;
    push_rows(tbl[0].rows);
    push_vecs(tbl[0].vecs, 0, 2);
    exp_q.push_back(tbl[0].expv);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (vec_pops - pv0 >= 2) break;
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("starve_no_pop", row_pop | vec_pop, 0);
      check("starve_busy", busy, 1);
    end
    @(posedge clk);
    #2;
    push_vecs(tbl[0].vecs, 2, 2);
    drain("starve");
    check("starve_row_pops", row_pops - pr0, 4);
    check("starve_vec_pops", vec_pops - pv0, 4);

    // Mid-product reset after the third MAC; no result expected for it.
    pr0 = row_pops;
    push_rows(tbl[5].rows);
    push_vecs(tbl[5].vecs, 0, 4);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (row_pops - pr0 >= 3) break;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_result", result, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_row_pop", row_pop, 0);
    check("midrst_vec_pop", vec_pop, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #2;
    row_q.delete();
    vec_q.delete();
    row_empty = 1'b1;
    vec_empty = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #2;
    run_entry(3);

    check("pop_rules", rule_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mxv_dot_engine.md
MXV_DOT_ENGINE -- requirements
Module: mxv_dot_engine

Interface
REQ-001 The block SHALL have parameter DW, default 8: width of each operand element.
REQ-002 The block SHALL have parameter N_ELEM, default 4: number of element pairs per dot product, 2 or more.
REQ-003 The block SHALL have parameter ACC_W, default 16: width of the accumulator and result.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port row_data, input, DW bits: head element of the upstream matrix-row FIFO.
REQ-007 The block SHALL have port row_empty, input, 1 bit: matrix-row FIFO empty flag.
REQ-008 The block SHALL have port row_pop, output, 1 bit: pop strobe to the matrix-row FIFO.
REQ-009 The block SHALL have port vec_data, input, DW bits: head element of the upstream vector FIFO.
REQ-010 The block SHALL have port vec_empty, input, 1 bit: vector FIFO empty flag.
REQ-011 The block SHALL have port vec_pop, output, 1 bit: pop strobe to the vector FIFO.
REQ-012 The block SHALL have port result, output, ACC_W bits: completed dot product.
REQ-013 The block SHALL have port result_valid, output, 1 bit: result holds a completed dot product.
REQ-014 The block SHALL have port result_ready, input, 1 bit: downstream accepts result.
REQ-015 The block SHALL have port busy, output, 1 bit: a dot product is in progress or pending handoff.

Function
REQ-016 The block SHALL implement four states: IDLE, POP, MAC and DONE.
REQ-017 In IDLE or POP, when row_empty=0 and vec_empty=0, the block SHALL assert row_pop and vec_pop together for exactly one cycle and then go to MAC; otherwise both pops SHALL stay 0 and the state SHALL hold.
REQ-018 The block SHALL never pop one FIFO without the other, and SHALL never pop a FIFO whose empty flag is 1.
REQ-019 In MAC, the block SHALL sample row_data and vec_data (FIFO read data valid the cycle after pop) and set acc <= acc + row_data*vec_data, using unsigned arithmetic truncated to ACC_W bits.
REQ-020 The element counter SHALL increment in MAC; if it reaches N_ELEM, the block SHALL go to DONE, otherwise to POP.
REQ-021 The first MAC of each dot product SHALL load acc with the product, ignoring the previous acc.
REQ-022 On entry to DONE, result SHALL equal the final acc, result_valid SHALL be 1, and no pops SHALL occur.
REQ-023 In DONE, result and result_valid SHALL stay stable until a cycle in which result_ready=1; the block SHALL then return to IDLE, clear the counter, and deassert result_valid the next cycle.
REQ-024 Throughput SHALL be 2 cycles per element pair plus 1 handoff cycle, i.e. a minimum of 2*N_ELEM+1 cycles per result.
REQ-025 busy SHALL be 0 only in IDLE.
REQ-026 An empty flag rising while the block waits in POP SHALL stall it with no change to acc or the counter.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, acc=0, counter=0, result=0, result_valid=0, row_pop=0, vec_pop=0 and busy=0.
REQ-028 A reset asserted mid-product SHALL discard the partial sum; after release, the block SHALL start a fresh product from the next FIFO heads.

Configuration
REQ-029 Configuration SHALL be controlled by the macro MXV_DOT_SAT_EN.
REQ-030 With MXV_DOT_SAT_EN defined, any accumulation whose true sum exceeds 2^ACC_W-1 SHALL clamp acc to all-ones, and acc SHALL stay clamped for the rest of that product.
REQ-031 With MXV_DOT_SAT_EN undefined, accumulation SHALL wrap modulo 2^ACC_W.

Verification
REQ-032 Basic: with defaults, rows 1,2,3,4 and vec 5,6,7,8 preloaded and result_ready=1 -> result=70, result_valid high 1 cycle, exactly 4 pops per FIFO.
REQ-033 Overflow: rows and vec all 255, N_ELEM=4 -> result=63492 without the macro and 65535 with MXV_DOT_SAT_EN.
REQ-034 Backpressure: result_ready=0 for 5 cycles after result_valid rises -> result and result_valid stable, no pops, handoff completes on the cycle result_ready=1.
REQ-035 Starvation: vec_empty=1 after 2 elements for 6 cycles -> pops halt and acc holds; after refill, the final result is correct.
REQ-036 Mid-operation reset: rst pulse after the 3rd MAC -> all outputs 0; a new product from fresh data gives its correct value.
REQ-037 Back-to-back: 8 pairs preloaded -> two results delivered, each 2*N_ELEM+1 cycles apart with result_ready=1.
